// File: rtl/cplx_pkg.sv
// Shared widths and FSM state type for the complex frame accumulator.
package cplx_pkg;

   localparam int CPLX_IN_W  = 16;
   localparam int CPLX_LEN_W = 8;

   // One extra integer bit per length bit: a full frame of the most negative
   // sample is the largest magnitude the accumulator ever has to hold.
   function automatic int acc_w(input int in_w, input int len_w);
      return in_w + len_w;
   endfunction

   localparam int CPLX_ACC_W = acc_w(CPLX_IN_W, CPLX_LEN_W);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_e;

endpackage

// File: rtl/cplx_acc_lane.sv
// One signed accumulator lane: load a fresh sample, add a sample, or hold.
module cplx_acc_lane
   import cplx_pkg::*;
#(
   parameter int IN_W  = CPLX_IN_W,
   parameter int ACC_W = CPLX_ACC_W
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    load_i,
   input  logic                    add_i,
   input  logic signed [IN_W-1:0]  din_i,
   output logic signed [ACC_W-1:0] acc_o
);

   logic signed [ACC_W-1:0] acc_q;
   logic signed [ACC_W-1:0] acc_d;
   logic signed [ACC_W-1:0] din_ext;

   assign din_ext = {{(ACC_W-IN_W){din_i[IN_W-1]}}, din_i};

   // load wins over add so a new frame never inherits the previous sum
   always_comb begin
      acc_d = acc_q;
      if (load_i) begin
         acc_d = din_ext;
      end else if (add_i) begin
         acc_d = acc_q + din_ext;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         acc_q <= '0;
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_o = acc_q;

endmodule

// File: rtl/cplx_accum.sv
// Complex frame accumulator: sums frame_len complex samples, then holds the
// result under a valid/ready handshake before starting the next frame.
module cplx_accum
   import cplx_pkg::*;
#(
   parameter int IN_W  = CPLX_IN_W,
   parameter int LEN_W = CPLX_LEN_W,
   parameter int ACC_W = acc_w(IN_W, LEN_W)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [LEN_W-1:0]        frame_len,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_real,
   input  logic signed [IN_W-1:0]  in_imag,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] acc_real,
   output logic signed [ACC_W-1:0] acc_imag
);

   // One extra bit so a zero length field can stand for 2^LEN_W.
   localparam int CNT_W = LEN_W + 1;
   localparam logic [CNT_W-1:0] LEN_FULL = {1'b1, {LEN_W{1'b0}}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] len_q, len_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic             accept;
   logic             load;
   logic             add;

   assign accept = in_valid & in_ready_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      len_d   = len_q;
      load    = 1'b0;
      add     = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               len_d   = (frame_len == '0) ? LEN_FULL : {1'b0, frame_len};
               cnt_d   = CNT_ONE;
               load    = 1'b1;
               state_d = (len_d == CNT_ONE) ? HOLD : ACCUM;
            end
         end
         ACCUM: begin
            if (accept) begin
               add   = 1'b1;
               cnt_d = cnt_q + CNT_ONE;
               if (cnt_d == len_q) begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      // Handshake outputs are registered from the next state so they line up
      // with the state they describe.
      in_ready_d  = (state_d != HOLD);
      out_valid_d = (state_d == HOLD);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         len_q       <= '0;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         len_q       <= len_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;

   cplx_acc_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
   ) u_lane_real (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .load_i (load),
      .add_i  (add),
      .din_i  (in_real),
      .acc_o  (acc_real)
   );

   cplx_acc_lane #(
      .IN_W  (IN_W),
      .ACC_W (ACC_W)
   ) u_lane_imag (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .load_i (load),
      .add_i  (add),
      .din_i  (in_imag),
      .acc_o  (acc_imag)
   );

endmodule

// File: tb/tb_cplx_accum.sv
// Directed and randomized bench for cplx_accum with a frame-sum reference model.
module tb_cplx_accum;

   localparam int IN_W  = 16;
   localparam int LEN_W = 8;
   localparam int ACC_W = 24;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic [LEN_W-1:0]        frame_len;
   logic                    in_valid;
   logic                    in_ready;
   logic signed [IN_W-1:0]  in_real;
   logic signed [IN_W-1:0]  in_imag;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [ACC_W-1:0] acc_real;
   logic signed [ACC_W-1:0] acc_imag;

   int checks   = 0;
   int failures = 0;

   cplx_accum #(
      .IN_W  (IN_W),
      .LEN_W (LEN_W),
      .ACC_W (ACC_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .frame_len (frame_len),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_real   (in_real),
      .in_imag   (in_imag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .acc_real  (acc_real),
      .acc_imag  (acc_imag)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [63:0] obs,
                      input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic signed [IN_W-1:0] rnd16();
      return IN_W'($urandom);
   endfunction

   // Offer one sample and wait (bounded) until it is taken; returns at the
   // falling edge right after the accepting rising edge.
   task automatic send(input logic signed [IN_W-1:0] re,
                       input logic signed [IN_W-1:0] im);
      logic ok;
      logic rdy;
      ok       = 1'b0;
      in_real  = re;
      in_imag  = im;
      in_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         rdy = in_ready;
         @(negedge clk);
         if (rdy) begin
            ok = 1'b1;
            break;
         end
      end
      in_valid = 1'b0;
      if (!ok) chk("accept_timeout", 64'(ok), 64'sd1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   // Expect a held frame sum, keep it held for hold_c cycles, then take it.
   task automatic finish(input string tag, input longint exp_re,
                         input longint exp_im, input int hold_c);
      chk({tag, "_valid"}, 64'(out_valid), 64'sd1);
      chk({tag, "_re"}, 64'(acc_real), exp_re);
      chk({tag, "_im"}, 64'(acc_imag), exp_im);
      chk({tag, "_rdy_hold"}, 64'(in_ready), 64'sd0);
      for (int i = 0; i < hold_c; i++) begin
         @(negedge clk);
         chk({tag, "_hold_valid"}, 64'(out_valid), 64'sd1);
         chk({tag, "_hold_re"}, 64'(acc_real), exp_re);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk({tag, "_valid_drop"}, 64'(out_valid), 64'sd0);
      chk({tag, "_rdy_back"}, 64'(in_ready), 64'sd1);
      chk({tag, "_after_re"}, 64'(acc_real), exp_re);
      chk({tag, "_after_im"}, 64'(acc_imag), exp_im);
   endtask

   // Random frame of n samples; the model is simply the running complex sum.
   task automatic frame_rand(input string tag, input int n, input int maxgap,
                             input int hold_c);
      longint sre;
      longint sim;
      logic signed [IN_W-1:0] r;
      logic signed [IN_W-1:0] q;
      sre = 0;
      sim = 0;
      frame_len = LEN_W'(n);
      for (int k = 0; k < n; k++) begin
         r = rnd16();
         q = rnd16();
         sre += longint'(r);
         sim += longint'(q);
         if (k > 0) idle($urandom_range(maxgap, 0));
         send(r, q);
         if (k == 0) frame_len = LEN_W'($urandom);
         if (k < n - 1) chk({tag, "_early_valid"}, 64'(out_valid), 64'sd0);
      end
      finish(tag, sre, sim, hold_c);
   endtask

   initial begin
      logic signed [IN_W-1:0] hr;
      logic signed [IN_W-1:0] hi;
      longint sre;
      longint sim;

      rst_n     = 1'b1;
      frame_len = '0;
      in_valid  = 1'b0;
      in_real   = '0;
      in_imag   = '0;
      out_ready = 1'b0;

      // Asynchronous reset before any clock edge
      #1 rst_n = 1'b0;
      #1;
      chk("rst_valid", 64'(out_valid), 64'sd0);
      chk("rst_ready", 64'(in_ready), 64'sd0);
      chk("rst_re", 64'(acc_real), 64'sd0);
      chk("rst_im", 64'(acc_imag), 64'sd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rst_ready_pre_edge", 64'(in_ready), 64'sd0);
      @(negedge clk);
      chk("rst_ready_post_edge", 64'(in_ready), 64'sd1);

      // Four-sample frame, back to back
      frame_len = 8'd4;
      send(16'sd1, 16'sd2);
      send(16'sd3, -16'sd4);
      send(-16'sd5, 16'sd6);
      chk("f4_early_valid", 64'(out_valid), 64'sd0);
      send(16'sd7, 16'sd8);
      finish("f4", 6, 12, 0);

      // Single-sample frame at the extremes
      frame_len = 8'd1;
      send(-16'sd32768, 16'sd32767);
      finish("f1", -32768, 32767, 1);

      // Zero length means 256 samples; most negative sum must not wrap
      frame_len = 8'd0;
      for (int k = 0; k < 256; k++) begin
         send(-16'sd32768, -16'sd32768);
         if (k == 254) chk("f256_early_valid", 64'(out_valid), 64'sd0);
      end
      finish("f256", -8388608, -8388608, 0);

      // Back-pressure in HOLD with a sample waiting upstream
      frame_len = 8'd2;
      sre = 0;
      sim = 0;
      for (int k = 0; k < 2; k++) begin
         hr = rnd16();
         hi = rnd16();
         sre += longint'(hr);
         sim += longint'(hi);
         send(hr, hi);
      end
      hr = rnd16();
      hi = rnd16();
      in_real  = hr;
      in_imag  = hi;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_ready", 64'(in_ready), 64'sd0);
         chk("bp_valid", 64'(out_valid), 64'sd1);
         chk("bp_re", 64'(acc_real), sre);
         chk("bp_im", 64'(acc_imag), sim);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("bp_valid_drop", 64'(out_valid), 64'sd0);
      chk("bp_ready_back", 64'(in_ready), 64'sd1);
      chk("bp_kept_re", 64'(acc_real), sre);
      send(hr, hi);
      chk("bp_load_re", 64'(acc_real), longint'(hr));
      chk("bp_load_im", 64'(acc_imag), longint'(hi));
      chk("bp_load_valid", 64'(out_valid), 64'sd0);
      sre = longint'(hr);
      sim = longint'(hi);
      hr = rnd16();
      hi = rnd16();
      sre += longint'(hr);
      sim += longint'(hi);
      send(hr, hi);
      finish("bp_next", sre, sim, 0);

      // Reset mid-frame discards the partial sum
      frame_len = 8'd4;
      send(16'sd100, -16'sd200);
      send(16'sd300, 16'sd400);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_re", 64'(acc_real), 64'sd0);
      chk("mid_rst_im", 64'(acc_imag), 64'sd0);
      chk("mid_rst_ready", 64'(in_ready), 64'sd0);
      chk("mid_rst_valid", 64'(out_valid), 64'sd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("mid_rst_no_pulse", 64'(out_valid), 64'sd0);
      for (int k = 0; k < 4; k++) send(16'sd1, 16'sd1);
      finish("post_rst", 4, 4, 0);

      // Reset while holding a result
      frame_len = 8'd2;
      send(16'sd55, -16'sd66);
      send(16'sd11, 16'sd22);
      chk("hold_rst_pre_valid", 64'(out_valid), 64'sd1);
      #2 rst_n = 1'b0;
      #1;
      chk("hold_rst_valid", 64'(out_valid), 64'sd0);
      chk("hold_rst_re", 64'(acc_real), 64'sd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("hold_rst_after_valid", 64'(out_valid), 64'sd0);
      chk("hold_rst_after_ready", 64'(in_ready), 64'sd1);

      // Gapped frame of three with frame_len disturbed after latching
      frame_len = 8'd3;
      for (int k = 0; k < 3; k++) begin
         if (k > 0) idle($urandom_range(3, 0));
         send(16'sd10, -16'sd10);
         frame_len = 8'd1 + 8'(k);
         if (k < 2) chk("gap_early_valid", 64'(out_valid), 64'sd0);
      end
      finish("gap", 30, -30, 2);

      // Randomized frames: lengths, data, gaps and hold times
      for (int f = 0; f < 10; f++) begin
         frame_rand("rand", $urandom_range(6, 1), 3, $urandom_range(3, 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/cplx_accum.md
CPLX_ACCUM -- requirements
Module: cplx_accum

Interface
REQ-001 SHALL have parameter IN_W, default 16, meaning the input sample width per component (signed).
REQ-002 SHALL have parameter LEN_W, default 8, meaning the width of the frame-length field.
REQ-003 SHALL have parameter ACC_W, default IN_W+LEN_W (24), meaning the accumulator and result width per component (signed).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-006 SHALL have port frame_len, input, LEN_W, the samples per frame; 0 means 2^LEN_W.
REQ-007 SHALL have port in_valid, input, 1, meaning an input sample is offered.
REQ-008 SHALL have port in_ready, output, 1, meaning a sample is accepted this cycle when in_valid=1.
REQ-009 SHALL have ports in_real and in_imag, input, IN_W each, the signed complex product from the upstream multiplier (z_real/z_imag).
REQ-010 SHALL have port out_valid, output, 1, meaning the frame sum is held on the outputs.
REQ-011 SHALL have port out_ready, input, 1, meaning the downstream stage takes the result.
REQ-012 SHALL have ports acc_real and acc_imag, output, ACC_W each, the signed frame sums.

Function
REQ-013 SHALL implement the FSM states IDLE, ACCUM and HOLD.
REQ-014 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in HOLD.
REQ-015 SHALL define accept as in_valid & in_ready.
REQ-016 On accept in IDLE, SHALL latch frame_len (0 maps to 2^LEN_W), load accumulators with sign-extended inputs (not added to old sums), and set count=1.
REQ-017 From IDLE, SHALL go to HOLD if the latched length is 1, and otherwise to ACCUM.
REQ-018 On accept in ACCUM, SHALL add sign-extended inputs to the accumulators and increment count.
REQ-019 When that accept completes the latched length, SHALL go to HOLD.
REQ-020 SHALL ignore frame_len changes after latching until the next IDLE accept.
REQ-021 In HOLD, SHALL assert out_valid=1 with acc_real/acc_imag stable.
REQ-022 In HOLD, when out_ready=1, SHALL go to IDLE; out_valid is 0 the next cycle.
REQ-023 Latency: out_valid SHALL rise on the cycle after the accept of the last sample of a frame.
REQ-024 Throughput: SHALL accept at most one sample per cycle, with gaps (in_valid=0) allowed anywhere without losing state.
REQ-025 No overflow is possible: |sum| <= 2^(IN_W-1)*2^LEN_W fits in ACC_W signed; no saturation logic SHALL exist.
REQ-026 Outputs SHALL be registered; acc_* SHALL hold the last frame sum after the HOLD handshake until the next frame's first accept.
REQ-027 If in_valid=1 during HOLD, the sample SHALL not be accepted, and the upstream holds it.

Reset
REQ-028 While rst_n=0, SHALL put the state in IDLE, with count=0, latched length=0, acc_real=0, acc_imag=0, out_valid=0 and in_ready=0, regardless of clk.
REQ-029 After rst_n deasserts, in_ready SHALL be 1 from the first rising clk edge.
REQ-030 Reset mid-frame or in HOLD SHALL discard the partial or held sum with no out_valid pulse.

Structure
REQ-031 Shared package cplx_pkg SHALL hold IN_W and LEN_W defaults, the ACC_W derivation, and the state enum {IDLE, ACCUM, HOLD}.
REQ-032 Sub-module cplx_acc_lane (one signed accumulator with load/add/hold controls) SHALL be instantiated twice (real, imag).
REQ-033 The FSM and counter SHALL reside in cplx_accum.

Verification
REQ-034 frame_len=4, samples (1,2),(3,-4),(-5,6),(7,8) back-to-back -> out_valid rises one cycle after the 4th accept; acc=(6,12).
REQ-035 frame_len=1, sample (-32768,32767) -> next cycle out_valid=1, acc=(-32768,32767) sign-extended.
REQ-036 frame_len=0, 256 samples of (-32768,-32768) -> acc=(-8388608,-8388608), no wrap.
REQ-037 HOLD with out_ready=0 for 5 cycles and in_valid=1 -> in_ready=0, acc stable, the held sample is accepted after the handshake as a new frame's first sample.
REQ-038 rst_n pulled low asynchronously after 2 of 4 samples -> outputs zero immediately; a new frame of (1,1)x4 yields (4,4).
REQ-039 frame_len=3 with in_valid gaps of 0-3 cycles between samples (10,-10) -> acc=(30,-30), and frame_len changes mid-frame are ignored.
